// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/CSR responder for the scpu datapath.
// Holds the M-mode trap CSRs. It captures trap state when an exception commits
// at MEM. It sequences a fixed-length flush before redirecting the PC either to
// mtvec (trap) or to mepc (mret).
module trap_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 3,
    parameter logic [63:0] MTVEC_RESET  = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_valid,
    input  logic [63:0] exc_cause,
    input  logic [31:0] exc_pc,
    input  logic [63:0] exc_tval,
    input  logic        mret_valid,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [63:0] csr_wdata,
    output logic [63:0] csr_rdata,
    output logic [63:0] mtvec_data,
    output logic [63:0] mepc_data,
    output logic        set_pc_to_mepc,
    output logic        trap_redirect,
    output logic        flush,
    output logic        busy,
    output logic        mstatus_mie
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;

    // The drain counter is loaded with FLUSH_CYCLES-1 so the redirect lands on
    // the last flush cycle.
    localparam logic [3:0]  CNT_INIT   = 4'(FLUSH_CYCLES - 1);
    localparam logic [63:0] ALIGN_MASK = ~64'h3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRAP_DRAIN,
        S_MRET_DRAIN
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;

    logic        r_mie, r_mpie;
    logic [63:0] r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

    logic        w_idle, w_exc_acc, w_mret_acc, w_csr_wr;
    logic [63:0] w_csr_old, w_csr_new;

    // Apply a CSR instruction's operation to the current register value.
    function automatic logic [63:0] csr_apply(input logic [1:0]  op,
                                              input logic [63:0] old_v,
                                              input logic [63:0] wdata);
        case (op)
            2'b01:   csr_apply = wdata;
            2'b10:   csr_apply = old_v | wdata;
            2'b11:   csr_apply = old_v & ~wdata;
            default: csr_apply = old_v;
        endcase
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign w_exc_acc  = w_idle && exc_valid;
    assign w_mret_acc = w_idle && mret_valid && !exc_valid;
    assign w_csr_wr   = w_idle && csr_we && (csr_op != 2'b00);

    // Combinational CSR read of the pre-write value; MPP always reads as M-mode.
    always_comb begin
        w_csr_old = 64'h0;
        case (csr_addr)
            A_MSTATUS:  w_csr_old = {51'b0, 2'b11, 3'b0, r_mpie, 3'b0, r_mie, 3'b0};
            A_MTVEC:    w_csr_old = r_mtvec;
            A_MSCRATCH: w_csr_old = r_mscratch;
            A_MEPC:     w_csr_old = r_mepc;
            A_MCAUSE:   w_csr_old = r_mcause;
            A_MTVAL:    w_csr_old = r_mtval;
            default:    w_csr_old = 64'h0;
        endcase
    end

    assign w_csr_new   = csr_apply(csr_op, w_csr_old, csr_wdata);
    assign csr_rdata   = w_csr_old;
    assign mtvec_data  = r_mtvec;
    assign mepc_data   = r_mepc;
    assign mstatus_mie = r_mie;

    // FSM state and drain counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic; flush/busy/pulses decode from the registered state only.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        flush          = 1'b0;
        busy           = 1'b0;
        trap_redirect  = 1'b0;
        set_pc_to_mepc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (exc_valid) begin
                    w_state_nxt = S_TRAP_DRAIN;
                    w_cnt_nxt   = CNT_INIT;
                end else if (mret_valid) begin
                    w_state_nxt = S_MRET_DRAIN;
                    w_cnt_nxt   = CNT_INIT;
                end
            end
            S_TRAP_DRAIN, S_MRET_DRAIN: begin
                flush = 1'b1;
                busy  = 1'b1;
                if (r_cnt == 4'd0) begin
                    trap_redirect  = (r_state == S_TRAP_DRAIN);
                    set_pc_to_mepc = (r_state == S_MRET_DRAIN);
                    w_state_nxt    = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // CSR storage. The CSR write comes first. A trap capture or an mret
    // update then overrides it for the registers they own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET;
            r_mscratch <= 64'h0;
            r_mepc     <= 64'h0;
            r_mcause   <= 64'h0;
            r_mtval    <= 64'h0;
        end else begin
            if (w_csr_wr) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        r_mie  <= w_csr_new[3];
                        r_mpie <= w_csr_new[7];
                    end
                    A_MTVEC:    r_mtvec    <= w_csr_new & ALIGN_MASK;
                    A_MSCRATCH: r_mscratch <= w_csr_new;
                    A_MEPC:     r_mepc     <= w_csr_new & ALIGN_MASK;
                    A_MCAUSE:   r_mcause   <= w_csr_new;
                    A_MTVAL:    r_mtval    <= w_csr_new;
                    default:    ;
                endcase
            end
            if (w_exc_acc) begin
                r_mepc   <= {32'b0, exc_pc} & ALIGN_MASK;
                r_mcause <= exc_cause;
                r_mtval  <= exc_tval;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (w_mret_acc) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: vector table, hand-written drain sequences and randomized
// traffic for trap_ctrl, all compared against a cycle-numbered reference model.
module tb_trap_ctrl;

    localparam int F = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_valid = 1'b0;
    logic [63:0] exc_cause = '0;
    logic [31:0] exc_pc = '0;
    logic [63:0] exc_tval = '0;
    logic        mret_valid = 1'b0;
    logic        csr_we = 1'b0;
    logic [1:0]  csr_op = '0;
    logic [11:0] csr_addr = 12'h300;
    logic [63:0] csr_wdata = '0;
    logic [63:0] csr_rdata, mtvec_data, mepc_data;
    logic        set_pc_to_mepc, trap_redirect, flush, busy, mstatus_mie;

    always #5 clk = ~clk;

    trap_ctrl #(.FLUSH_CYCLES(F), .MTVEC_RESET(64'h0)) dut (
        .clk(clk), .rst(rst),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
        .mret_valid(mret_valid),
        .csr_we(csr_we), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(csr_rdata), .mtvec_data(mtvec_data), .mepc_data(mepc_data),
        .set_pc_to_mepc(set_pc_to_mepc), .trap_redirect(trap_redirect),
        .flush(flush), .busy(busy), .mstatus_mie(mstatus_mie)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Reference model: architectural registers plus the window of cycle numbers
    // during which a drain is in progress.
    logic        m_mie, m_mpie;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
    int          m_cyc, m_start, m_end, m_kind;

    task automatic model_reset();
        m_mie = 0; m_mpie = 0;
        m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cyc = 0; m_start = 1; m_end = 0; m_kind = 0;
    endtask

    function automatic logic [63:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 64'h1800 | (64'(m_mpie) << 7) | (64'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            default: return 64'h0;
        endcase
    endfunction

    task automatic model_step(input logic busy_now);
        logic [63:0] old_v, nv;
        if (!busy_now) begin
            if (csr_we && csr_op != 2'b00) begin
                old_v = m_read(csr_addr);
                nv = (csr_op == 2'b01) ? csr_wdata :
                     (csr_op == 2'b10) ? (old_v | csr_wdata) : (old_v & ~csr_wdata);
                case (csr_addr)
                    12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                    12'h305: m_mtvec = nv & ~64'h3;
                    12'h340: m_mscratch = nv;
                    12'h341: m_mepc = nv & ~64'h3;
                    12'h342: m_mcause = nv;
                    12'h343: m_mtval = nv;
                    default: ;
                endcase
            end
            if (exc_valid) begin
                m_mepc = {32'b0, exc_pc} & ~64'h3;
                m_mcause = exc_cause;
                m_mtval = exc_tval;
                m_mpie = m_mie;
                m_mie = 0;
                m_kind = 1; m_start = m_cyc + 1; m_end = m_cyc + F;
            end else if (mret_valid) begin
                m_mie = m_mpie;
                m_mpie = 1;
                m_kind = 2; m_start = m_cyc + 1; m_end = m_cyc + F;
            end
        end
        m_cyc++;
    endtask

    // Compare every output against the model mid-cycle, then advance one clock.
    task automatic tick();
        logic b;
        @(negedge clk);
        b = (m_cyc >= m_start) && (m_cyc <= m_end);
        chk("csr_rdata", csr_rdata, m_read(csr_addr));
        chk("mtvec_data", mtvec_data, m_mtvec);
        chk("mepc_data", mepc_data, m_mepc);
        chk("mstatus_mie", 64'(mstatus_mie), 64'(m_mie));
        chk("flush", 64'(flush), 64'(b));
        chk("busy", 64'(busy), 64'(b));
        chk("trap_redirect", 64'(trap_redirect), 64'(b && m_cyc == m_end && m_kind == 1));
        chk("set_pc_to_mepc", 64'(set_pc_to_mepc), 64'(b && m_cyc == m_end && m_kind == 2));
        @(posedge clk);
        model_step(b);
        #1;
    endtask

    task automatic clear_in();
        exc_valid = 0; mret_valid = 0; csr_we = 0; csr_op = 2'b00;
    endtask

    task automatic set_csr(input logic [1:0] op, input logic [11:0] a, input logic [63:0] d);
        csr_we = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    endtask

    task automatic set_exc(input logic [31:0] pc, input logic [63:0] cause, input logic [63:0] tval);
        exc_valid = 1; exc_pc = pc; exc_cause = cause; exc_tval = tval;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_old;
        logic [63:0] exp_new;
    } vec_t;

    vec_t tbl[14];
    logic [11:0] addrs[7] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0};

    initial begin
        tbl[0]  = '{2'b01, 12'h305, 64'h104, 64'h0, 64'h104};
        tbl[1]  = '{2'b01, 12'h305, 64'h107, 64'h104, 64'h104};
        tbl[2]  = '{2'b10, 12'h300, 64'h8, 64'h1800, 64'h1808};
        tbl[3]  = '{2'b11, 12'h300, 64'h8, 64'h1808, 64'h1800};
        tbl[4]  = '{2'b01, 12'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1800, 64'h1888};
        tbl[5]  = '{2'b01, 12'h300, 64'h0, 64'h1888, 64'h1800};
        tbl[6]  = '{2'b01, 12'h340, 64'hDEAD_BEEF_0123_4567, 64'h0, 64'hDEAD_BEEF_0123_4567};
        tbl[7]  = '{2'b10, 12'h340, 64'hF0, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_45F7};
        tbl[8]  = '{2'b11, 12'h340, 64'hFFFF_0000_0000_0000, 64'hDEAD_BEEF_0123_45F7, 64'h0000_BEEF_0123_45F7};
        tbl[9]  = '{2'b01, 12'h341, 64'h203, 64'h0, 64'h200};
        tbl[10] = '{2'b01, 12'h342, 64'h11, 64'h0, 64'h11};
        tbl[11] = '{2'b01, 12'h343, 64'h55, 64'h0, 64'h55};
        tbl[12] = '{2'b01, 12'h7FF, 64'h1234, 64'h0, 64'h0};
        tbl[13] = '{2'b00, 12'h340, 64'hFFFF, 64'h0000_BEEF_0123_45F7, 64'h0000_BEEF_0123_45F7};

        // Power-on reset
        model_reset();
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_flush", 64'(flush), 64'h0);
        chk("rst_mtvec", mtvec_data, 64'h0);
        chk("rst_mepc", mepc_data, 64'h0);
        chk("rst_mstatus", csr_rdata, 64'h1800);
        @(negedge clk); rst = 0;
        @(posedge clk); m_cyc++; #1;

        // CSR vector table
        for (int i = 0; i < 14; i++) begin
            set_csr(tbl[i].op, tbl[i].addr, tbl[i].wdata);
            #1;
            chk($sformatf("tbl%0d_old", i), csr_rdata, tbl[i].exp_old);
            tick();
            clear_in();
            #1;
            chk($sformatf("tbl%0d_new", i), csr_rdata, tbl[i].exp_new);
        end
        chk("tbl_mtvec_data", mtvec_data, 64'h104);

        // Trap with MIE set
        set_csr(2'b10, 12'h300, 64'h8);
        tick(); clear_in(); #1;
        chk("mie_set", 64'(mstatus_mie), 64'h1);
        set_exc(32'h203, 64'd11, 64'h0);
        tick(); clear_in();
        for (int k = 1; k <= F; k++) begin
            #1;
            chk($sformatf("trap_flush%0d", k), 64'(flush), 64'h1);
            chk($sformatf("trap_redir%0d", k), 64'(trap_redirect), 64'(k == F));
            tick();
        end
        csr_addr = 12'h342; #1;
        chk("trap_busy_after", 64'(busy), 64'h0);
        chk("trap_mepc", mepc_data, 64'h200);
        chk("trap_mcause", csr_rdata, 64'd11);
        csr_addr = 12'h300; #1;
        chk("trap_mstatus", csr_rdata, 64'h1880);

        // mret back out
        mret_valid = 1;
        tick(); clear_in();
        for (int k = 1; k <= F; k++) begin
            #1;
            chk($sformatf("mret_flush%0d", k), 64'(flush), 64'h1);
            chk($sformatf("mret_setpc%0d", k), 64'(set_pc_to_mepc), 64'(k == F));
            chk($sformatf("mret_mepc%0d", k), mepc_data, 64'h200);
            tick();
        end
        #1;
        chk("mret_mstatus", csr_rdata, 64'h1888);
        chk("mret_busy_after", 64'(busy), 64'h0);

        // Exception, mret and an mcause write together: exception wins
        set_exc(32'h300, 64'd2, 64'hBAD);
        mret_valid = 1;
        set_csr(2'b01, 12'h342, 64'h77);
        tick(); clear_in();
        for (int k = 1; k <= F; k++) begin
            #1;
            chk($sformatf("both_setpc%0d", k), 64'(set_pc_to_mepc), 64'h0);
            chk($sformatf("both_redir%0d", k), 64'(trap_redirect), 64'(k == F));
            tick();
        end
        #1;
        chk("both_mcause", csr_rdata, 64'd2);
        chk("both_mepc", mepc_data, 64'h300);
        chk("both_mie", 64'(mstatus_mie), 64'h0);

        // Exception with an mtvec write (applies); all events during drain ignored
        set_exc(32'h400, 64'd5, 64'h0);
        set_csr(2'b01, 12'h305, 64'h800);
        tick(); clear_in();
        for (int k = 1; k <= F; k++) begin
            set_exc(32'h9990, 64'd9, 64'h1);
            mret_valid = 1;
            set_csr(2'b01, 12'h340, 64'h1);
            tick();
        end
        clear_in();
        csr_addr = 12'h340; #1;
        chk("busy_ign_busy", 64'(busy), 64'h0);
        chk("busy_ign_mtvec", mtvec_data, 64'h800);
        chk("busy_ign_mepc", mepc_data, 64'h400);
        chk("busy_ign_mscratch", csr_rdata, 64'h0000_BEEF_0123_45F7);

        // Reset during the second drain cycle
        set_exc(32'h500, 64'd3, 64'h0);
        tick(); clear_in();
        tick();
        rst = 1; #1;
        model_reset();
        chk("midrst_flush", 64'(flush), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_redir", 64'(trap_redirect), 64'h0);
        chk("midrst_mepc", mepc_data, 64'h0);
        @(negedge clk); rst = 0;
        @(posedge clk); m_cyc++; #1;
        for (int k = 0; k < F + 2; k++) begin
            chk($sformatf("postrst_redir%0d", k), 64'(trap_redirect | set_pc_to_mepc), 64'h0);
            tick();
        end
        chk("postrst_mepc", mepc_data, 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            exc_valid  = ($urandom_range(0, 7) == 0);
            mret_valid = ($urandom_range(0, 7) == 0);
            exc_pc     = $urandom;
            exc_cause  = {$urandom, $urandom};
            exc_tval   = {$urandom, $urandom};
            csr_we     = ($urandom_range(0, 1) == 1) && !(mret_valid && !exc_valid);
            csr_op     = 2'($urandom_range(0, 3));
            csr_addr   = addrs[$urandom_range(0, 6)];
            csr_wdata  = {$urandom, $urandom};
            tick();
        end
        clear_in();
        for (int i = 0; i < F + 1; i++) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Machine-mode trap and CSR responder for the scpu datapath.
- Owns mstatus, mtvec, mscratch, mepc, mcause and mtval.
- Captures trap state when an exception commits at MEM, and sequences pipeline drain on exception and mret.
- Drives mtvec_data, mepc_data and a one-cycle set_pc_to_mepc to the PC register, plus flush to the pipeline registers.

Parameters:
FLUSH_CYCLES, 3, cycles flush stays high after a trap/mret accept (valid range 1..15).
MTVEC_RESET, 64'h0, mtvec value after reset.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
exc_valid  input  1  instruction in MEM commits an exception (ecall, unimp, illegal)
exc_cause  input  64  mcause value for that exception
exc_pc  input  32  PC of the faulting instruction
exc_tval  input  64  mtval value (0 for ecall)
mret_valid  input  1  mret commits in MEM
csr_we  input  1  CSR instruction commits in WB
csr_op  input  2  01=RW, 10=RS (set bits), 11=RC (clear bits), 00=no write
csr_addr  input  12  CSR address
csr_wdata  input  64  rs1/zimm operand
csr_rdata  output  64  combinational read of csr_addr (old value)
mtvec_data  output  64  current mtvec
mepc_data  output  64  current mepc
set_pc_to_mepc  output  1  one-cycle PC redirect to mepc
trap_redirect  output  1  one-cycle PC redirect to mtvec
flush  output  1  squash IF/ID/EX/MEM contents
busy  output  1  FSM not IDLE
mstatus_mie  output  1  global interrupt enable

Behaviour:
- Reset (async, immediate):
  - State IDLE, drain counter 0.
  - mtvec=MTVEC_RESET; mepc, mcause, mtval, mscratch = 0; MIE=0, MPIE=0.
  - All pulse outputs and busy/flush low.
  - Reset mid-drain abandons the sequence; no redirect is issued.
- CSR map:
  - 0x300 mstatus: MIE bit3 and MPIE bit7 writable; MPP[12:11] reads 2'b11; other bits read 0.
  - 0x305 mtvec: direct mode only; bits[1:0] forced 0 on write.
  - 0x340 mscratch.
  - 0x341 mepc: bits[1:0] forced 0 on write.
  - 0x342 mcause.
  - 0x343 mtval.
  - Unmapped address: reads 0; writes ignored.
- CSR write value:
  - RW: new = wdata.
  - RS: new = old | wdata.
  - RC: new = old & ~wdata.
  - Applied on the clk edge when csr_we=1, csr_op!=0 and state IDLE.
  - csr_rdata always returns the pre-write value.
- FSM states: IDLE, TRAP_DRAIN, MRET_DRAIN.
- IDLE and exc_valid=1 (accept):
  - mepc={32'b0, exc_pc[31:2], 2'b00}; mcause=exc_cause; mtval=exc_tval; MPIE<=MIE; MIE<=0.
  - counter<=FLUSH_CYCLES-1; go TRAP_DRAIN.
- IDLE and mret_valid=1 (no exc_valid):
  - MIE<=MPIE; MPIE<=1.
  - counter<=FLUSH_CYCLES-1; go MRET_DRAIN.
- DRAIN states:
  - flush=1 and busy=1 registered, starting the cycle after accept.
  - Counter decrements each cycle.
  - On the cycle counter==0, assert trap_redirect (TRAP_DRAIN) or set_pc_to_mepc (MRET_DRAIN) for exactly that cycle; next state IDLE.
  - Redirect lands FLUSH_CYCLES cycles after the accept edge; flush is high for exactly FLUSH_CYCLES cycles.
- Simultaneous events and conflicts:
  - exc_valid and mret_valid together: exception wins; mret is dropped.
  - Exception and csr_we together: CSR write still applies unless it targets mstatus/mepc/mcause/mtval; for those, the exception capture wins.
  - exc_valid, mret_valid and csr_we while busy: ignored, since the pipeline is being squashed.
- mepc_data and mtvec_data reflect registered values; updates are visible the cycle after the write edge.

Test Plan:
- Reset then write mtvec=0x104 via RW at 0x305 -> mtvec_data=0x104 next cycle; write of 0x107 -> reads 0x104.
- MIE=1, exc_valid with exc_pc=0x200, cause=11, FLUSH_CYCLES=3 -> mepc=0x200, mcause=11, MIE=0, MPIE=1; flush high 3 cycles; trap_redirect pulse on 3rd cycle only; busy low after.
- mret_valid after that trap -> MIE=1, MPIE=1; set_pc_to_mepc single pulse 3 cycles later with mepc_data=0x200.
- exc_valid and mret_valid same cycle -> TRAP_DRAIN taken; no set_pc_to_mepc pulse.
- CSR RS 0x8 then RC 0x8 on mstatus -> mstatus_mie 1 then 0; csr_rdata on the RS cycle shows the old value (MPP=11 visible as 0x1800).
- Assert rst during the 2nd drain cycle -> flush, busy and pulses drop immediately; no redirect after release; mepc=0.
